// File: rtl/opnd_fetch_pkg.sv
// Shared widths and ALU control encodings for the operand-fetch stage.
package opnd_fetch_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREG  = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ALUC_ADD = 3'b000,
        ALUC_SUB = 3'b001,
        ALUC_AND = 3'b010,
        ALUC_OR  = 3'b011,
        ALUC_XOR = 3'b100,
        ALUC_SLT = 3'b101
    } aluc_e;

endpackage

// File: rtl/opnd_fetch_regfile.sv
// Register file: two combinational read ports with writeback bypass, one
// synchronous write port, index 0 hardwired to zero.
module opnd_fetch_regfile
    import opnd_fetch_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic                 wb_en_i,
    input  logic [REG_IDX_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [XLEN-1:0]      rdata1_o,
    output logic [XLEN-1:0]      rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            wr_live;

    assign wr_live = wb_en_i && (wb_rd_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_live) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // A writeback to the register being read is forwarded in the same cycle.
    always_comb begin
        rdata1_o = regs_q[rs1_i];
        if (rs1_i == '0) begin
            rdata1_o = '0;
        end else if (wr_live && (wb_rd_i == rs1_i)) begin
            rdata1_o = wb_data_i;
        end
    end

    always_comb begin
        rdata2_o = regs_q[rs2_i];
        if (rs2_i == '0) begin
            rdata2_o = '0;
        end else if (wr_live && (wb_rd_i == rs2_i)) begin
            rdata2_o = wb_data_i;
        end
    end

endmodule

// File: rtl/opnd_fetch.sv
// Operand-fetch stage: reads sources from the register file and presents a
// registered operand bundle to the ALU behind a single-entry valid/ready slot.
module opnd_fetch
    import opnd_fetch_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [XLEN-1:0]      imm,
    input  logic                 use_imm,
    input  logic [2:0]           aluc_in,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      a,
    output logic [XLEN-1:0]      b,
    output logic [2:0]           ALUC,
    output logic [REG_IDX_W-1:0] out_rd
);

    logic [XLEN-1:0]      rdata1, rdata2;
    logic                 accept;

    logic                 valid_q, valid_d;
    logic [XLEN-1:0]      a_q, a_d;
    logic [XLEN-1:0]      b_q, b_d;
    logic [2:0]           aluc_q, aluc_d;
    logic [REG_IDX_W-1:0] rd_q, rd_d;

    opnd_fetch_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .wb_en_i   (wb_en),
        .wb_rd_i   (wb_rd),
        .wb_data_i (wb_data),
        .rdata1_o  (rdata1),
        .rdata2_o  (rdata2)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Operands are frozen at acceptance; later writebacks never refresh a held bundle.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        aluc_d  = aluc_q;
        rd_d    = rd_q;
        if (accept) begin
            valid_d = 1'b1;
            a_d     = rdata1;
            b_d     = use_imm ? imm : rdata2;
            aluc_d  = aluc_in;
            rd_d    = rd;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            aluc_q  <= ALUC_ADD;
            rd_q    <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aluc_q  <= aluc_d;
            rd_q    <= rd_d;
        end
    end

    assign out_valid = valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign ALUC      = aluc_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_opnd_fetch.sv
// Self-checking bench for opnd_fetch: directed scenarios plus a randomized run
// against a behavioural register-file/handshake model.
module tb_opnd_fetch;
    import opnd_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  aluc_in;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic [2:0]  ALUC;
    logic [4:0]  out_rd;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_R [32];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_aluc;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    opnd_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .use_imm   (use_imm),
        .aluc_in   (aluc_in),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ALUC      (ALUC),
        .out_rd    (out_rd)
    );

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (wb_en && wb_rd == idx) return wb_data;
        return m_R[idx];
    endfunction

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic cycle();
        logic [31:0] ra, rb;
        logic        acc;
        ra  = mread(rs1);
        rb  = use_imm ? imm : mread(rs2);
        acc = in_valid && (!m_valid || out_ready);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_R[i] = 32'h0;
            m_valid = 1'b0; m_a = 0; m_b = 0; m_aluc = 0; m_rd = 0;
        end else begin
            if (wb_en && wb_rd != 0) m_R[wb_rd] = wb_data;
            if (acc) begin
                m_valid = 1'b1; m_a = ra; m_b = rb; m_aluc = aluc_in; m_rd = rd;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle();
        in_valid = 0; wb_en = 0; out_ready = 1; use_imm = 0;
        rs1 = 0; rs2 = 0; rd = 0; imm = 0; aluc_in = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic issue(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                         input logic ui, input logic [31:0] im, input logic [2:0] ac);
        in_valid = 1; rs1 = r1; rs2 = r2; rd = d; use_imm = ui; imm = im; aluc_in = ac;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        for (int i = 0; i < 32; i++) m_R[i] = 32'hx;
        cycle(); cycle();
        rst = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (a !== 32'h0 || b !== 32'h0) begin failures++; $display("FAIL reset_ab got a=%h b=%h exp=0", a, b); end
        checks++; if (ALUC !== 3'b000 || out_rd !== 5'd0) begin failures++; $display("FAIL reset_ctl got aluc=%0d rd=%0d exp=0", ALUC, out_rd); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        idle();
        wb_en = 1; wb_rd = 5; wb_data = 32'h0000_00AA;
        cycle();
        idle();
        issue(5, 0, 9, 0, 0, ALUC_ADD);
        cycle();
        idle();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
        checks++; if (a !== 32'hAA) begin failures++; $display("FAIL basic_a got=%h exp=000000aa", a); end
        checks++; if (b !== 32'h0) begin failures++; $display("FAIL basic_b got=%h exp=0", b); end
        checks++; if (ALUC !== 3'b000 || out_rd !== 5'd9) begin failures++; $display("FAIL basic_ctl got aluc=%0d rd=%0d exp 0/9", ALUC, out_rd); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
        checks++; if (a !== 32'hAA) begin failures++; $display("FAIL basic_hold_a got=%h exp=000000aa", a); end
    endtask

    task automatic test_bypass();
        idle();
        wb_en = 1; wb_rd = 3; wb_data = 32'h1234;
        issue(3, 5, 4, 0, 0, ALUC_SUB);
        cycle();
        idle();
        checks++; if (a !== 32'h1234) begin failures++; $display("FAIL bypass_a got=%h exp=00001234", a); end
        checks++; if (b !== 32'hAA || ALUC !== 3'b001) begin failures++; $display("FAIL bypass_b got b=%h aluc=%0d exp=000000aa/1", b, ALUC); end
        cycle();
    endtask

    task automatic test_x0();
        idle();
        wb_en = 1; wb_rd = 0; wb_data = 32'hFFFF_FFFF;
        issue(0, 0, 1, 0, 0, ALUC_OR);
        cycle();
        idle();
        checks++; if (a !== 32'h0 || b !== 32'h0) begin failures++; $display("FAIL x0_bypass got a=%h b=%h exp=0", a, b); end
        issue(0, 3, 1, 0, 0, ALUC_OR);
        cycle();
        idle();
        checks++; if (a !== 32'h0 || b !== 32'h1234) begin failures++; $display("FAIL x0_read got a=%h b=%h exp=0/00001234", a, b); end
        cycle();
    endtask

    task automatic test_imm();
        idle();
        wb_en = 1; wb_rd = 7; wb_data = 32'd9;
        cycle();
        idle();
        issue(7, 7, 2, 1, 32'hFFFF_FFF0, ALUC_SLT);
        cycle();
        issue(7, 7, 2, 0, 32'hFFFF_FFF0, ALUC_SLT);
        checks++; if (b !== 32'hFFFF_FFF0 || a !== 32'd9) begin failures++; $display("FAIL imm_sel got a=%h b=%h exp=9/fffffff0", a, b); end
        cycle();
        idle();
        checks++; if (b !== 32'd9) begin failures++; $display("FAIL imm_off got b=%h exp=9", b); end
        cycle();
    endtask

    task automatic test_stall();
        idle();
        wb_en = 1; wb_rd = 10; wb_data = 32'h55;
        cycle();
        idle();
        issue(10, 0, 1, 0, 0, ALUC_XOR);
        cycle();
        out_ready = 0;
        issue(10, 0, 2, 0, 0, ALUC_AND);
        wb_en = 1; wb_rd = 10; wb_data = 32'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
            cycle();
            wb_en = 0;
            checks++;
            if (out_valid !== 1'b1 || a !== 32'h55 || b !== 32'h0 || ALUC !== 3'b100 || out_rd !== 5'd1) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%0b a=%h b=%h aluc=%0d rd=%0d exp 1/55/0/4/1", k, out_valid, a, b, ALUC, out_rd);
            end
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || a !== 32'h77 || ALUC !== 3'b010 || out_rd !== 5'd2) begin
            failures++;
            $display("FAIL release_swap got v=%0b a=%h aluc=%0d rd=%0d exp 1/77/2/2", out_valid, a, ALUC, out_rd);
        end
        cycle();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_reset_stall();
        idle();
        issue(10, 5, 3, 0, 0, ALUC_SUB);
        cycle();
        out_ready = 0;
        issue(5, 10, 4, 0, 0, ALUC_ADD);
        cycle();
        rst = 1; wb_en = 1; wb_rd = 11; wb_data = 32'hDEAD;
        cycle();
        rst = 0;
        idle();
        #1;
        checks++; if (out_valid !== 1'b0 || a !== 32'h0 || b !== 32'h0) begin failures++; $display("FAIL rst_stall got v=%0b a=%h b=%h exp 0/0/0", out_valid, a, b); end
        for (int i = 0; i < 32; i++) begin
            issue(5'(i), 5'(31 - i), 5'(i), 0, 0, ALUC_ADD);
            cycle();
            checks++; if (a !== 32'h0 || b !== 32'h0) begin failures++; $display("FAIL rst_regs idx=%0d got a=%h b=%h exp 0", i, a, b); end
        end
        idle();
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rs1       = 5'($urandom_range(0, 7));
            rs2       = 5'($urandom_range(0, 7));
            rd        = 5'($urandom);
            use_imm   = $urandom_range(0, 1) == 1;
            imm       = $urandom;
            aluc_in   = 3'($urandom_range(0, 5));
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            rst       = ($urandom_range(0, 79) == 0);
            #1;
            checks++;
            if (in_ready !== (!m_valid || out_ready)) begin
                failures++;
                $display("FAIL rand_in_ready n=%0d got=%0b exp=%0b", n, in_ready, !m_valid || out_ready);
            end
            cycle();
            rst = 0;
            checks++;
            if (out_valid !== m_valid || a !== m_a || b !== m_b || ALUC !== m_aluc || out_rd !== m_rd) begin
                failures++;
                $display("FAIL rand_out n=%0d got v=%0b a=%h b=%h aluc=%0d rd=%0d exp v=%0b a=%h b=%h aluc=%0d rd=%0d",
                         n, out_valid, a, b, ALUC, out_rd, m_valid, m_a, m_b, m_aluc, m_rd);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle();
        m_valid = 0; m_a = 0; m_b = 0; m_aluc = 0; m_rd = 0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_bypass();
        test_x0();
        test_imm();
        test_stall();
        test_reset_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opnd_fetch.md
OPND_FETCH -- requirements
Module: opnd_fetch

Interface
REQ-001 Parameter XLEN, default 32: datapath width of register contents and operands.
REQ-002 Parameter NREG, default 32: number of architectural registers; index width is 5 bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  decode slot presents an instruction.
REQ-006 in_ready  output  1  stage can accept this cycle.
REQ-007 rs1, rs2  input  5 each  source register indices.
REQ-008 rd  input  5  destination index, passed through.
REQ-009 imm  input  XLEN  sign-extended immediate.
REQ-010 use_imm  input  1  1: operand b = imm; 0: operand b = R[rs2].
REQ-011 aluc_in  input  3  ALU control code, passed through unchanged.
REQ-012 wb_en, wb_rd, wb_data  input  1/5/XLEN  writeback port into the register file.
REQ-013 out_valid  output  1  operand bundle valid toward ALU.
REQ-014 out_ready  input  1  ALU-side consumer accepts the bundle.
REQ-015 a, b  output  XLEN each  registered operands driving the ALU a/b inputs.
REQ-016 ALUC  output  3  registered ALU control code.
REQ-017 out_rd  output  5  registered destination index.

Function
REQ-018 Register file: NREG x XLEN storage, two combinational read ports, one synchronous write port.
REQ-019 Write: when wb_en=1 and wb_rd!=0, R[wb_rd] <= wb_data at the clock edge.
REQ-020 R[0] reads 0 always; writes to index 0 are discarded.
REQ-021 Bypass: when wb_en=1, wb_rd!=0, and wb_rd equals rs1 (or rs2), that read returns wb_data in the same cycle.
REQ-022 in_ready = !out_valid || out_ready (single-entry output register, no bubble on back-to-back).
REQ-023 Accept when in_valid && in_ready: capture a=R[rs1], b=(use_imm ? imm : R[rs2]), ALUC=aluc_in, out_rd=rd; out_valid <= 1 the next cycle; latency 1 clock.
REQ-024 Drain when out_valid && out_ready && !(in_valid && in_ready): out_valid <= 0.
REQ-025 Stall when out_valid && !out_ready: a, b, ALUC, out_rd, out_valid held bit-stable; in_ready=0.
REQ-026 Held operands are not refreshed by writebacks arriving during a stall; values are frozen at acceptance.
REQ-027 Writeback proceeds independently of handshake state, including during stall.
REQ-028 Simultaneous accept and drain: new bundle replaces old in the same edge, out_valid stays 1.
REQ-029 Outputs a, b, ALUC, out_rd are don't-care-free: when out_valid=0 they hold their last value (0 after reset).

Reset
REQ-030 rst=1 at a clock edge: out_valid=0, a=0, b=0, ALUC=3'b000, out_rd=0, all R[i]=0.
REQ-031 rst has priority over writeback and acceptance in the same cycle; a mid-stall bundle is discarded.
REQ-032 in_ready evaluates to 1 in the first cycle after reset deasserts.

Structure
REQ-033 Shared package holds XLEN, NREG, register-index width, and the 3-bit ALUC codes (ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101).
REQ-034 One sub-module, regfile: storage, x0 rule, and write-to-read bypass; opnd_fetch holds handshake and output register.

Verification
REQ-035 Reset, then write wb_rd=5, data 0x0000_00AA; next cycle issue rs1=5, rs2=0, use_imm=0, ALUC=000 -> one cycle later out_valid=1, a=0xAA, b=0, ALUC=000.
REQ-036 Same-cycle write wb_rd=3, data 0x1234 and issue rs1=3 -> a=0x1234 (bypass).
REQ-037 Write wb_rd=0, data 0xFFFF_FFFF; issue rs1=0 -> a=0.
REQ-038 use_imm=1, imm=0xFFFF_FFF0, rs2=7 with R[7]=9 -> b=0xFFFF_FFF0.
REQ-039 Hold out_ready=0 for 3 cycles with in_valid=1 and a write to the held rs1 -> in_ready=0, a/b/ALUC unchanged; on out_ready=1 the queued instruction is accepted the same edge and out_valid stays 1.
REQ-040 Assert rst during stall -> next cycle out_valid=0, a=b=0, and all R[i] read 0.
